ctrlsoc_mlspi: RTL and testbench
================================

// Module: ctrlsoc_mlspi
// PURPOSE
//  Quad-SPI host for the mlaccel PMOD (ml_clk/ml_csb/ml_io[3:0]/ml_irq/ml_err); downstream bus slave of the ctrlsoc CPU.
//  Converts CPU register accesses into nibble-wide byte transfers; frames chip-select under software control.
//  Decoded by ctrlsoc at 0x0300_0000..0x0300_000F; drives ctrlsoc mem_ready/mem_rdata mux like other slaves.
// PARAMETERS
//  CLKDIV        1  clk cycles per ml_clk half-period (>=1); SCK period = 2*CLKDIV clk
//  DUMMY_CYCLES  2  SCK periods with io tristated before first read after a write / frame start
// PORTS
//  clk        in   1   system clock
//  resetn     in   1   synchronous, active-low reset
//  sel        in   1   ctrlsoc address decode hit (mem_valid && addr in window)
//  mem_addr   in   4   byte address in window; [3:2] = register index
//  mem_wstrb  in   4   byte write strobes; 0 = read
//  mem_wdata  in   32  write data
//  mem_rdata  out  32  read data, valid while mem_ready=1
//  mem_ready  out  1   one-cycle completion pulse
//  ml_clk     out  1   SPI clock, idle low (mode 0)
//  ml_csb     out  1   chip select, active low
//  io_oe      out  4   per-line output enable to pad sub-module
//  io_do      out  4   output nibble, io_do[3] = MSB
//  io_di      in   4   input nibble from pads
//  ml_irq     in   1   async accelerator interrupt
//  ml_err     in   1   async accelerator error
// BEHAVIOUR
//  Reset: ml_clk=0, ml_csb=1, io_oe=0, io_do=0, mem_ready=0, mem_rdata=0, err_sticky=0, dir=WRITE, state IDLE; mid-transfer reset aborts immediately.
//  Registers: 0 CTRL/STAT W bit0=1 -> csb release, bit1=1 -> clear err_sticky; R {29'b0, busy, irq_sync, err_sticky}.
//   1 DATA8 W: send bytes whose wstrb bit set, ascending byte order; R: receive 1 byte -> rdata[7:0], upper 0.
//   2 DATA32 R: receive 4 bytes, first byte -> rdata[7:0] (little endian); W: same as DATA8 W.
//   3 reserved: mem_ready next cycle, rdata 0, no side effects.
//  ml_irq/ml_err: 2-flop synchronised; err_sticky sets on synced ml_err=1, clear has lower priority than set in same cycle.
//  FSM: IDLE -> (DATA access) START -> [TURN] -> SHIFT_OUT | SHIFT_IN -> DONE -> IDLE.
//   START: if ml_csb=1 drive ml_csb=0 and dir := WRITE; one clk.
//   TURN: entered for a read when dir=WRITE; io_oe=0, DUMMY_CYCLES SCK pulses; then dir := READ.
//   SHIFT_OUT: io_oe=1111; nibble updated while ml_clk low, high nibble first; 2 SCK periods per byte.
//   SHIFT_IN: io_oe=0000; io_di sampled on clk edge where ml_clk rises; high nibble first.
//   DONE: mem_ready=1 one cycle; ml_clk returns low; ml_csb stays low (frame held between accesses).
//  Write after read: io_oe=1111 at SHIFT_OUT entry, no dummy cycles, dir := WRITE.
//  CTRL write: serviced only in IDLE (bus held otherwise); release sets ml_csb=1 on the mem_ready cycle; releasing an idle bus is a no-op.
//  Latency (CLKDIV=1): 1-byte write, csb already low: mem_ready 2*2*CLKDIV+2 = 6 clk after sel; +1 if frame start.
//  sel held by CPU until mem_ready; sel low in IDLE -> no action; requests ignored while busy except completion of current one.
//  busy = state != IDLE; write with wstrb!=0 to DATA32 allowed; write of wstrb=0 is a read.
// STRUCTURE
//  Package ctrlsoc_pkg: register index localparams (REG_CTRL=0, REG_DATA8=1, REG_DATA32=2), FSM state enum, window base 32'h0300_0000.
//  Sub-module ctrlsoc_mlspi_pads: four SB_IO (PIN_TYPE 6'b1010_01, no pullup) mapping io_oe/io_do/io_di to ml_io[3:0]; instantiated by ctrlsoc beside this block.
//  Core contains clock divider counter, byte/nibble counters, 32-bit shift register, FSM.
// TESTING
//  Reset, then DATA8 write 0x0000_00A5 wstrb=0001 -> csb falls, io_do 0xA then 0x5 on 2 rising edges, mem_ready once, csb stays 0.
//  DATA32 write 0x4433_2211 wstrb=1111 -> 8 nibbles 1,1,2,2,3,3,4,4 on ml_io, io_oe=1111 throughout.
//  After write, DATA8 read with model driving 0xC3 -> 2 dummy SCK with io_oe=0, then rdata=0x0000_00C3.
//  DATA32 read twice back-to-back, model bytes 0x10..0x17 -> 0x1312_1110 then 0x1716_1514, no dummy on second read.
//  CTRL write 0x1 -> ml_csb=1 on mem_ready; ml_err pulse 1 clk -> STAT bit0=1 until CTRL write 0x2.
//  resetn low mid SHIFT_OUT (CLKDIV=3) -> next clk ml_csb=1, ml_clk=0, io_oe=0, no mem_ready.

Source files
------------

// File: rtl/ctrlsoc_pkg.sv
// Shared definitions for the ctrlsoc mlaccel quad-SPI host: register map, FSM encoding
// and byte-packing helpers used by the core.
package ctrlsoc_pkg;

    localparam logic [31:0] MLSPI_BASE = 32'h0300_0000;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_DATA8  = 2'd1;
    localparam logic [1:0] REG_DATA32 = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_TURN,
        ST_SHIFT_OUT,
        ST_SHIFT_IN,
        ST_DONE
    } mlspi_state_e;

    typedef enum logic {
        DIR_WRITE = 1'b0,
        DIR_READ  = 1'b1
    } mlspi_dir_e;

    function automatic logic [2:0] popcnt4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

    // Strobed bytes packed from the top down so the shifter always emits sr[31:28] next.
    function automatic logic [31:0] pack_tx(input logic [31:0] wdata, input logic [3:0] wstrb);
        logic [31:0] r;
        int k;
        r = '0;
        k = 0;
        for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) begin
                r[31-8*k -: 8] = wdata[8*i +: 8];
                k++;
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] le_word(input logic [31:0] sr);
        return {sr[7:0], sr[15:8], sr[23:16], sr[31:24]};
    endfunction

endpackage

// File: rtl/ctrlsoc_mlspi_sync.sv
// Two-flop synchroniser for the asynchronous accelerator status lines.
module ctrlsoc_mlspi_sync #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q, meta_d;
    logic [W-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/ctrlsoc_mlspi.sv
// Quad-SPI host for the mlaccel PMOD: turns CPU register accesses into nibble-wide
// byte transfers, with chip-select framed by software.
module ctrlsoc_mlspi
    import ctrlsoc_pkg::*;
#(
    parameter int unsigned CLKDIV       = 1,
    parameter int unsigned DUMMY_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        sel,
    input  logic [3:0]  mem_addr,
    input  logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        ml_clk,
    output logic        ml_csb,
    output logic [3:0]  io_oe,
    output logic [3:0]  io_do,
    input  logic [3:0]  io_di,
    input  logic        ml_irq,
    input  logic        ml_err
);

    localparam logic [15:0] DIV_LOAD   = 16'(CLKDIV - 1);
    localparam logic [7:0]  DUMMY_LOAD = 8'(DUMMY_CYCLES);

    mlspi_state_e state_q, state_d;
    mlspi_dir_e   dir_q, dir_d;
    logic         csb_q, csb_d;
    logic         sck_q, sck_d;
    logic [15:0]  div_q, div_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [7:0]   nib_q, nib_d;
    logic [31:0]  sr_q, sr_d;
    logic         rd_q, rd_d;
    logic         word_q, word_d;
    logic         ready_q, ready_d;
    logic [31:0]  rdata_q, rdata_d;
    logic         err_q, err_d;

    logic irq_s, err_s, busy, tick, sck_rise, sck_fall, err_clr;
    logic unused_addr_lsb;

    assign unused_addr_lsb = &{1'b0, mem_addr[1:0]};

    ctrlsoc_mlspi_sync #(.W(2)) u_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      ({ml_irq, ml_err}),
        .q      ({irq_s, err_s})
    );

    assign busy = (state_q != ST_IDLE);

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        csb_d    = csb_q;
        sck_d    = sck_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        nib_d    = nib_q;
        sr_d     = sr_q;
        rd_d     = rd_q;
        word_d   = word_q;
        ready_d  = 1'b0;
        rdata_d  = '0;
        err_clr  = 1'b0;
        tick     = (div_q == 16'd0);
        sck_rise = tick && !sck_q;
        sck_fall = tick && sck_q;

        if (state_q inside {ST_TURN, ST_SHIFT_OUT, ST_SHIFT_IN}) begin
            if (tick) begin
                div_d = DIV_LOAD;
                sck_d = !sck_q;
            end else begin
                div_d = div_q - 16'd1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                sck_d = 1'b0;
                // ready_q still high means the CPU has not yet dropped sel for the last access
                if (sel && !ready_q) begin
                    case (mem_addr[3:2])
                        REG_CTRL: begin
                            ready_d = 1'b1;
                            if (mem_wstrb != 4'b0) begin
                                if (mem_wdata[0]) csb_d = 1'b1;
                                err_clr = mem_wdata[1];
                            end else begin
                                rdata_d = {29'b0, busy, irq_s, err_q};
                            end
                        end
                        REG_DATA8, REG_DATA32: begin
                            state_d = ST_START;
                            rd_d    = (mem_wstrb == 4'b0);
                            word_d  = (mem_addr[3:2] == REG_DATA32);
                            if (mem_wstrb == 4'b0) begin
                                nib_d = (mem_addr[3:2] == REG_DATA32) ? 8'd8 : 8'd2;
                                sr_d  = '0;
                            end else begin
                                nib_d = {4'b0, popcnt4(mem_wstrb), 1'b0};
                                sr_d  = pack_tx(mem_wdata, mem_wstrb);
                            end
                        end
                        default: ready_d = 1'b1;
                    endcase
                end
            end
            ST_START: begin
                if (csb_q) begin
                    csb_d = 1'b0;
                    dir_d = DIR_WRITE;
                end else begin
                    div_d = DIV_LOAD;
                    sck_d = 1'b0;
                    cnt_d = nib_q;
                    if (!rd_q) begin
                        state_d = ST_SHIFT_OUT;
                        dir_d   = DIR_WRITE;
                    end else if (dir_q == DIR_WRITE && DUMMY_LOAD != 8'd0) begin
                        state_d = ST_TURN;
                        cnt_d   = DUMMY_LOAD;
                    end else begin
                        state_d = ST_SHIFT_IN;
                        dir_d   = DIR_READ;
                    end
                end
            end
            ST_TURN: begin
                if (sck_fall) begin
                    if (cnt_q == 8'd1) begin
                        state_d = ST_SHIFT_IN;
                        dir_d   = DIR_READ;
                        cnt_d   = nib_q;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            ST_SHIFT_OUT: begin
                if (sck_fall) begin
                    sr_d = {sr_q[27:0], 4'h0};
                    if (cnt_q == 8'd1) begin
                        state_d = ST_DONE;
                        ready_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            ST_SHIFT_IN: begin
                if (sck_rise) sr_d = {sr_q[27:0], io_di};
                if (sck_fall) begin
                    if (cnt_q == 8'd1) begin
                        state_d = ST_DONE;
                        ready_d = 1'b1;
                        rdata_d = word_q ? le_word(sr_q) : {24'b0, sr_q[7:0]};
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            ST_DONE: begin
                sck_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // a set from the synchronised error line wins over a software clear
        err_d = err_s ? 1'b1 : (err_clr ? 1'b0 : err_q);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            dir_q   <= DIR_WRITE;
            csb_q   <= 1'b1;
            sck_q   <= 1'b0;
            div_q   <= DIV_LOAD;
            cnt_q   <= '0;
            nib_q   <= '0;
            sr_q    <= '0;
            rd_q    <= 1'b0;
            word_q  <= 1'b0;
            ready_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            csb_q   <= csb_d;
            sck_q   <= sck_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            nib_q   <= nib_d;
            sr_q    <= sr_d;
            rd_q    <= rd_d;
            word_q  <= word_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign ml_clk    = sck_q;
    assign ml_csb    = csb_q;
    assign io_oe     = (state_q == ST_SHIFT_OUT) ? 4'hF : 4'h0;
    assign io_do     = (state_q == ST_SHIFT_OUT) ? sr_q[31:28] : 4'h0;
    assign mem_ready = ready_q;
    assign mem_rdata = rdata_q;

endmodule

// File: tb/tb_ctrlsoc_mlspi.sv
// Directed bench for ctrlsoc_mlspi: bus tasks drive register accesses while an SPI
// device model captures output nibbles and supplies read nibbles.
module tb_ctrlsoc_mlspi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn, sel, ml_irq, ml_err;
    logic [3:0]  mem_addr, mem_wstrb, io_di;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_ready, ml_clk, ml_csb;
    logic [3:0]  io_oe, io_do;

    logic        resetn3, sel3, ready3, sck3, csb3;
    logic [3:0]  addr3, wstrb3, oe3, do3;
    logic [31:0] wdata3, rdata3;

    ctrlsoc_mlspi #(.CLKDIV(1), .DUMMY_CYCLES(2)) dut (
        .clk(clk), .resetn(resetn), .sel(sel), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .ml_clk(ml_clk), .ml_csb(ml_csb), .io_oe(io_oe), .io_do(io_do), .io_di(io_di),
        .ml_irq(ml_irq), .ml_err(ml_err)
    );

    ctrlsoc_mlspi #(.CLKDIV(3), .DUMMY_CYCLES(2)) dut3 (
        .clk(clk), .resetn(resetn3), .sel(sel3), .mem_addr(addr3), .mem_wstrb(wstrb3),
        .mem_wdata(wdata3), .mem_rdata(rdata3), .mem_ready(ready3),
        .ml_clk(sck3), .ml_csb(csb3), .io_oe(oe3), .io_do(do3), .io_di(4'h0),
        .ml_irq(1'b0), .ml_err(1'b0)
    );

    int checks = 0;
    int errors = 0;

    logic [3:0]  exp_nib_q[$];
    logic [31:0] exp_rd_q[$];

    logic [3:0] cap_mem [0:63];
    int cap_wr = 0;
    int cap_rd = 0;
    logic [3:0] rx_mem [0:63];
    int rx_wr = 0;
    int rx_rd = 0;
    int oe0_rises = 0;
    int oe_bad = 0;

    // SPI device model: records driven nibbles, consumes one read slot per SCK rise
    always @(posedge ml_clk) begin
        if (io_oe == 4'hF) begin
            cap_mem[cap_wr % 64] = io_do;
            cap_wr++;
        end else if (io_oe == 4'h0) begin
            oe0_rises++;
            if (rx_rd < rx_wr) rx_rd++;
        end else begin
            oe_bad++;
        end
    end

    always @(negedge clk) io_di = (rx_rd < rx_wr) ? rx_mem[rx_rd % 64] : 4'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic [3:0] addr, input logic [3:0] strb, input logic [31:0] wd,
                       output logic [31:0] rd, output int lat, output logic csb_rdy);
        sel = 1'b1; mem_addr = addr; mem_wstrb = strb; mem_wdata = wd;
        lat = 0; rd = '0; csb_rdy = 1'bx;
        for (int i = 1; i <= 200 && lat == 0; i++) begin
            @(posedge clk); #1;
            if (mem_ready) begin
                lat = i; rd = mem_rdata; csb_rdy = ml_csb;
            end
        end
        sel = 1'b0; mem_wstrb = 4'h0; mem_wdata = '0;
        chk("bus_completed", 32'(lat != 0), 32'd1);
        @(posedge clk); #1;
        chk("ready_one_cycle", 32'(mem_ready), 32'd0);
        chk("rdata_zero_after", mem_rdata, 32'd0);
    endtask

    task automatic do_write(input string tag, input logic [3:0] addr, input logic [3:0] strb,
                            input logic [31:0] wd, input int exp_lat);
        logic [31:0] rd; int lat; logic csb_rdy;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                exp_nib_q.push_back(wd[8*i+4 +: 4]);
                exp_nib_q.push_back(wd[8*i +: 4]);
            end
        end
        bus(addr, strb, wd, rd, lat, csb_rdy);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_csb_low"}, 32'(csb_rdy), 32'd0);
        while (exp_nib_q.size() > 0) begin
            logic [3:0] e;
            e = exp_nib_q.pop_front();
            chk({tag, "_nibble"}, 32'(cap_mem[cap_rd % 64]), 32'(e));
            cap_rd++;
        end
        chk({tag, "_nibble_count"}, 32'(cap_wr), 32'(cap_rd));
    endtask

    task automatic do_read(input string tag, input logic [3:0] addr, input int nbytes,
                           input logic [31:0] bw, input int dummy, input int exp_lat);
        logic [31:0] rd; int lat; logic csb_rdy; int rises0;
        for (int i = 0; i < dummy; i++) begin
            rx_mem[rx_wr % 64] = 4'h0; rx_wr++;
        end
        for (int i = 0; i < nbytes; i++) begin
            rx_mem[rx_wr % 64] = bw[8*i+4 +: 4]; rx_wr++;
            rx_mem[rx_wr % 64] = bw[8*i +: 4];   rx_wr++;
        end
        exp_rd_q.push_back((nbytes == 1) ? {24'b0, bw[7:0]} : bw);
        rises0 = oe0_rises;
        bus(addr, 4'h0, 32'h0, rd, lat, csb_rdy);
        chk({tag, "_rdata"}, rd, exp_rd_q.pop_front());
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_sck_in"}, 32'(oe0_rises - rises0), 32'(dummy + 2 * nbytes));
        chk({tag, "_csb_low"}, 32'(csb_rdy), 32'd0);
    endtask

    initial begin
        logic [31:0] rd; int lat; logic csb_rdy; bit seen;

        resetn = 1'b0; resetn3 = 1'b0; sel = 1'b0; mem_addr = '0; mem_wstrb = '0;
        mem_wdata = '0; ml_irq = 1'b0; ml_err = 1'b0;
        sel3 = 1'b0; addr3 = '0; wstrb3 = '0; wdata3 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ml_clk", 32'(ml_clk), 32'd0);
        chk("rst_csb", 32'(ml_csb), 32'd1);
        chk("rst_io_oe", 32'(io_oe), 32'd0);
        chk("rst_io_do", 32'(io_do), 32'd0);
        chk("rst_ready", 32'(mem_ready), 32'd0);
        chk("rst_rdata", mem_rdata, 32'd0);
        resetn = 1'b1; resetn3 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_no_ready", 32'(mem_ready), 32'd0);
        chk("idle_csb", 32'(ml_csb), 32'd1);

        bus(4'h0, 4'h0, 32'h0, rd, lat, csb_rdy);
        chk("stat_reset", rd, 32'd0);
        chk("stat_lat", 32'(lat), 32'd1);

        do_write("w8_a5", 4'h4, 4'b0001, 32'h0000_00A5, 7);
        chk("w8_csb_held", 32'(ml_csb), 32'd0);
        do_write("w32", 4'h8, 4'b1111, 32'h4433_2211, 18);
        do_read("r8_c3", 4'h4, 1, 32'h0000_00C3, 2, 10);
        do_read("r32_a", 4'h8, 4, 32'h1312_1110, 0, 18);
        do_read("r32_b", 4'h8, 4, 32'h1716_1514, 0, 18);
        do_write("w8_sparse", 4'h4, 4'b0101, 32'h00CC_00BB, 10);

        bus(4'hC, 4'h0, 32'h0, rd, lat, csb_rdy);
        chk("rsvd_rdata", rd, 32'd0);
        chk("rsvd_lat", 32'(lat), 32'd1);
        bus(4'hC, 4'hF, 32'hFFFF_FFFF, rd, lat, csb_rdy);
        chk("rsvd_w_csb", 32'(csb_rdy), 32'd0);

        bus(4'h0, 4'h1, 32'h1, rd, lat, csb_rdy);
        chk("release_csb_on_ready", 32'(csb_rdy), 32'd1);
        chk("release_lat", 32'(lat), 32'd1);
        bus(4'h0, 4'h1, 32'h1, rd, lat, csb_rdy);
        chk("release_idle_noop", 32'(csb_rdy), 32'd1);

        ml_err = 1'b1;
        @(posedge clk); #1;
        ml_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus(4'h0, 4'h0, 32'h0, rd, lat, csb_rdy);
        chk("err_sticky_set", rd, 32'h1);
        ml_irq = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus(4'h0, 4'h0, 32'h0, rd, lat, csb_rdy);
        chk("irq_and_err", rd, 32'h3);
        ml_irq = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus(4'h0, 4'h0, 32'h0, rd, lat, csb_rdy);
        chk("err_still_sticky", rd, 32'h1);
        bus(4'h0, 4'h1, 32'h2, rd, lat, csb_rdy);
        bus(4'h0, 4'h0, 32'h0, rd, lat, csb_rdy);
        chk("err_cleared", rd, 32'h0);

        do_read("r8_frame", 4'h4, 1, 32'h0000_005A, 2, 11);

        // reset in the middle of a slow write on the CLKDIV=3 instance
        sel3 = 1'b1; addr3 = 4'h4; wstrb3 = 4'b0001; wdata3 = 32'h0000_00A5;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge clk); #1;
            if (oe3 == 4'hF) seen = 1'b1;
        end
        chk("r3_reached_shift", 32'(seen), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        chk("r3_mid_shift_oe", 32'(oe3), 32'hF);
        resetn3 = 1'b0;
        @(posedge clk); #1;
        chk("r3_csb", 32'(csb3), 32'd1);
        chk("r3_sck", 32'(sck3), 32'd0);
        chk("r3_oe", 32'(oe3), 32'd0);
        chk("r3_ready", 32'(ready3), 32'd0);
        sel3 = 1'b0; wstrb3 = 4'h0;
        resetn3 = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (ready3) seen = 1'b1;
        end
        chk("r3_no_ready_after", 32'(seen), 32'd0);

        chk("oe_partial_never", 32'(oe_bad), 32'd0);
        chk("rx_all_consumed", 32'(rx_rd), 32'(rx_wr));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
